hb_dec_filter: RTL and testbench

HB_DEC_FILTER -- requirements
Module: hb_dec_filter

---
 rtl/hb_dec_filter.sv | 159 +++++++++++++++
 tb/tb_hb_dec_filter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hb_dec_filter.sv
// Half-band decimate-by-2 FIR: symmetric pre-add, serial MAC (one coefficient per cycle), round half up.
// Latency K+3 cycles from trigger to clk_vld_out; a trigger arriving while busy is dropped and flagged on ovf.
// Optional output clamping when HB_DEC_SAT_EN is defined; otherwise the result wraps to OW bits.
module hb_dec_filter #(
    parameter int DW        = 35,
    parameter int OW        = 35,
    parameter int CW        = 18,
    parameter int NTAP      = 11,
    parameter int COEF_FRAC = 17,
    parameter logic [((NTAP+1)/4)*CW-1:0] COEFS = {18'd4096, -18'sd8192, 18'd32768}
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 clk_vld_in,
    input  logic signed [DW-1:0] dat_in,
    output logic                 clk_vld_out,
    output logic        [OW-1:0] dat_out,
    output logic                 ovf,
    output logic                 sat
);

    localparam int K    = (NTAP + 1) / 4;
    localparam int C    = (NTAP - 1) / 2;
    localparam int CNTW = $clog2(K + 1);
    localparam int PW   = CW + DW + 1;
    localparam int AW   = DW + 1 + CW + $clog2(K + 1);
    localparam int RW   = AW + 1;

    localparam logic signed [RW-1:0] RHALF =
        {{(RW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] MAC   = 2'd2;
    localparam logic [1:0] ROUND = 2'd3;

    logic signed [DW-1:0]   x    [NTAP];
    logic signed [DW:0]     pre  [K];
    logic signed [CW-1:0]   coef [K];
    logic        [1:0]      state;
    logic                   phase;
    logic        [CNTW-1:0] cnt;
    logic signed [AW-1:0]   acc;

    logic                   trig;
    logic signed [DW:0]     pre_sel;
    logic signed [CW-1:0]   coef_sel;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [RW-1:0]   rsum;
    logic        [OW-1:0]   res;
    logic                   sat_c;

    for (genvar g = 0; g < K; g++) begin : g_coef
        assign coef[g] = COEFS[g*CW +: CW];
    end

    assign trig = clk_vld_in & phase;

    always_comb begin
        pre_sel  = '0;
        coef_sel = '0;
        for (int k = 0; k < K; k++) begin
            if (cnt == CNTW'(k)) begin
                pre_sel  = pre[k];
                coef_sel = coef[k];
            end
        end
    end

    assign prod     = {{(PW-CW){coef_sel[CW-1]}}, coef_sel} * {{(PW-DW-1){pre_sel[DW]}}, pre_sel};
    assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    assign rsum     = {acc[AW-1], acc} + RHALF;

`ifdef HB_DEC_SAT_EN
    localparam logic signed [RW-1:0] OMAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    logic signed [RW-1:0] rounded;

    assign rounded = rsum >>> COEF_FRAC;

    always_comb begin
        res   = rounded[OW-1:0];
        sat_c = 1'b0;
        if (rounded > OMAX) begin
            res   = OMAX[OW-1:0];
            sat_c = 1'b1;
        end else if (rounded < OMIN) begin
            res   = OMIN[OW-1:0];
            sat_c = 1'b1;
        end
    end
`else
    assign res   = OW'(rsum >>> COEF_FRAC);
    assign sat_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAP; i++) x[i] <= '0;
            for (int k = 0; k < K; k++) pre[k] <= '0;
            acc         <= '0;
            cnt         <= '0;
            phase       <= 1'b0;
            state       <= IDLE;
            clk_vld_out <= 1'b0;
            dat_out     <= '0;
            ovf         <= 1'b0;
            sat         <= 1'b0;
        end else if (clr) begin
            // dat_out deliberately holds its last value across a clear
            for (int i = 0; i < NTAP; i++) x[i] <= '0;
            for (int k = 0; k < K; k++) pre[k] <= '0;
            cnt         <= '0;
            phase       <= 1'b0;
            state       <= IDLE;
            clk_vld_out <= 1'b0;
            ovf         <= 1'b0;
            sat         <= 1'b0;
        end else begin
            clk_vld_out <= 1'b0;
            sat         <= 1'b0;
            ovf         <= trig && (state != IDLE);

            if (clk_vld_in) begin
                x[0] <= dat_in;
                for (int i = 1; i < NTAP; i++) x[i] <= x[i-1];
                phase <= ~phase;
            end

            case (state)
                IDLE: begin
                    if (trig) state <= LOAD;
                end
                LOAD: begin
                    // snapshot the taps so samples shifting in meanwhile cannot disturb this output
                    for (int k = 0; k < K; k++)
                        pre[k] <= {x[C-2*k-1][DW-1], x[C-2*k-1]} + {x[C+2*k+1][DW-1], x[C+2*k+1]};
                    acc   <= {{(AW-DW){x[C][DW-1]}}, x[C]} <<< (COEF_FRAC - 1);
                    cnt   <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (cnt == CNTW'(K - 1)) state <= ROUND;
                    else                     cnt   <= cnt + 1'b1;
                end
                default: begin
                    dat_out     <= res;
                    sat         <= sat_c;
                    clk_vld_out <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hb_dec_filter.sv
// Directed-vector bench for hb_dec_filter with a queue scoreboard checked by independent monitors.
module tb_hb_dec_filter;

    typedef struct { logic signed [34:0] d; logic s; } exp_t;
    typedef struct { logic signed [15:0] d; logic s; } exp16_t;

    logic        clk, rstn, clr;
    logic        vld, vout, ovf, sat;
    logic [34:0] din, dout;
    logic        v16, vout16, ovf16, sat16;
    logic [15:0] d16, dout16;

    int vectors = 0;
    int miscomp = 0;
    int cyc = 0;
    int ovf_cnt = 0;
    int out_cnt = 0;

    exp_t   q   [$];
    exp16_t q16 [$];

    hb_dec_filter u_dut (
        .clk(clk), .rstn(rstn), .clr(clr), .clk_vld_in(vld), .dat_in(din),
        .clk_vld_out(vout), .dat_out(dout), .ovf(ovf), .sat(sat)
    );

    hb_dec_filter #(
        .DW(16), .OW(16), .CW(18), .NTAP(11), .COEF_FRAC(17),
        .COEFS({18'd0, 18'd0, 18'd65536})
    ) u_dut16 (
        .clk(clk), .rstn(rstn), .clr(clr), .clk_vld_in(v16), .dat_in(d16),
        .clk_vld_out(vout16), .dat_out(dout16), .ovf(ovf16), .sat(sat16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic signed [34:0] act, input logic signed [34:0] exp);
        vectors++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor for the default-parameter instance
    always @(negedge clk) begin
        if (rstn) begin
            if (ovf) ovf_cnt++;
            if (vout) begin
                out_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_out", $signed(dout), 35'sd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("dat_out", $signed(dout), e.d);
                    chk("sat", {34'd0, sat}, {34'd0, e.s});
                end
            end
        end
    end

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        if (rstn && vout16) begin
            if (q16.size() == 0) begin
                chk("unexpected_out16", 35'($signed(dout16)), 35'sd0);
            end else begin
                exp16_t e;
                e = q16.pop_front();
                chk("dat_out16", 35'($signed(dout16)), 35'(e.d));
                chk("sat16", {34'd0, sat16}, {34'd0, e.s});
            end
        end
    end

    task automatic push(input int v);
        exp_t e;
        e.d = 35'(v);
        e.s = 1'b0;
        q.push_back(e);
    endtask

    task automatic push16(input int v, input logic s);
        exp16_t e;
        e.d = 16'(v);
        e.s = s;
        q16.push_back(e);
    endtask

    task automatic send(input int v, input int gap);
        @(posedge clk); #1;
        vld = 1'b1; din = 35'(v);
        @(posedge clk); #1;
        vld = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic send16(input int v, input int gap);
        @(posedge clk); #1;
        v16 = 1'b1; d16 = 16'(v);
        @(posedge clk); #1;
        v16 = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic do_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic drain();
        repeat (14) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, lat, o0, n0;
        rstn = 1'b0; clr = 1'b0; vld = 1'b0; din = '0; v16 = 1'b0; d16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", {34'd0, vout}, 35'sd0);
        chk("rst_dat", $signed(dout), 35'sd0);
        chk("rst_ovf", {34'd0, ovf}, 35'sd0);
        chk("rst_sat", {34'd0, sat}, 35'sd0);
        #1 rstn = 1'b1;

        // impulse on a trigger sample
        o0 = ovf_cnt;
        push(32); push(-64); push(256); push(256); push(-64); push(32); push(0); push(0);
        send(0, 4); send(1024, 4);
        for (int i = 0; i < 14; i++) send(0, 4);
        drain();

        // impulse on a non-trigger sample, plus trigger-to-output latency
        do_clr();
        push(0); push(0); push(512); push(0); push(0); push(0);
        send(1024, 4);
        @(posedge clk); #1;
        vld = 1'b1; din = '0; t0 = cyc;
        @(posedge clk); #1;
        vld = 1'b0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vout) begin
                lat = cyc - t0;
                break;
            end
        end
        chk("latency", 35'(lat), 35'sd6);
        for (int i = 0; i < 10; i++) send(0, 4);
        drain();

        // constant input settling to 938
        do_clr();
        push(31); push(-31); push(719); push(969); push(906); push(938); push(938); push(938);
        for (int i = 0; i < 16; i++) send(1000, 4);
        drain();
        chk("no_ovf_spaced", 35'(ovf_cnt - o0), 35'sd0);

        // sample every cycle: only every third trigger survives
        do_clr();
        o0 = ovf_cnt;
        push(31); push(969);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            vld = 1'b1; din = 35'd1000;
        end
        @(posedge clk); #1 vld = 1'b0;
        drain();
        chk("ovf_pulses", 35'(ovf_cnt - o0), 35'sd4);

        // clear during MAC aborts the output and keeps dat_out
        n0 = out_cnt;
        send(1000, 2); send(1000, 2);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        drain();
        chk("clr_abort", 35'(out_cnt - n0), 35'sd0);
        chk("clr_keeps_dat", $signed(dout), 35'sd969);

        // reset during MAC aborts the output and zeroes everything
        n0 = out_cnt;
        send(1000, 2); send(1000, 2);
        @(posedge clk); #1 rstn = 1'b0;
        @(negedge clk);
        chk("rst2_dat", $signed(dout), 35'sd0);
        chk("rst2_vld", {34'd0, vout}, 35'sd0);
        @(posedge clk); #1 rstn = 1'b1;
        drain();
        chk("rst_abort", 35'(out_cnt - n0), 35'sd0);

        // first trigger after reset is the second sample
        push(0);
        send(1024, 4); send(0, 4);
        drain();

        // 16-bit instance: clamp or wrap depending on build
        push16(0, 1'b0); push16(0, 1'b0); push16(32767, 1'b0);
        for (int i = 0; i < 5; i++) begin
`ifdef HB_DEC_SAT_EN
            push16(32767, 1'b1);
`else
            push16(-16385, 1'b0);
`endif
        end
        for (int i = 0; i < 16; i++) send16(32767, 4);
        drain();

        chk("sb_drain", 35'(q.size()), 35'sd0);
        chk("sb16_drain", 35'(q16.size()), 35'sd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
